// File: rtl/axis_forwarder_pkg.sv
// Shared constants and FSM encoding for the packet-filter forwarder.
// Defaults track the packetfilt packet memory geometry.
package axis_forwarder_pkg;

    localparam int FWD_PACKET_ADDR_WIDTH = 10;
    localparam int FWD_DATA_WIDTH        = 64;

    // Entries in the return-data FIFO; read credit is measured against this.
    localparam logic [1:0] FWD_FIFO_DEPTH = 2'd2;

    typedef enum logic [2:0] {
        FWD_IDLE   = 3'd0,
        FWD_STREAM = 3'd1,
        FWD_DRAIN  = 3'd2,
        FWD_DONE   = 3'd3,
        FWD_HOLD   = 3'd4
    } fwd_state_t;

    function automatic logic [31:0] fwd_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fwd_skid_fifo.sv
// Purpose: 2-entry FIFO holding returned packet words plus their last flag.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the producer only pushes when it holds credit.
module fwd_skid_fifo #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic             rd_ptr;
    logic             wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    mem1 <= push_dat;
                end else begin
                    mem0 <= push_dat;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = rd_ptr ? mem1 : mem0;

endmodule

// File: rtl/axis_forwarder.sv
// Purpose: streams an accepted packet from packet memory as 64-bit AXIS, then pulses forwarder_done.
// Latency: memory read 1 cycle, FIFO 1 cycle; 1 beat/cycle sustained. Optional FORWARDER_STATS_EN adds counters.
// Backpressure: reads issue only with FIFO credit; head beat held stable while tvalid & !tready.
module axis_forwarder
    import axis_forwarder_pkg::*;
#(
    parameter int PACKET_ADDR_WIDTH = FWD_PACKET_ADDR_WIDTH,
    parameter int DATA_WIDTH        = FWD_DATA_WIDTH
) (
    input  logic                         axi_aclk,
    input  logic                         axi_aresetn,
    input  logic                         ready_for_forwarder,
    input  logic [PACKET_ADDR_WIDTH-1:0] len_to_forwarder,
    output logic [PACKET_ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                         forwarder_rd_en,
    input  logic [DATA_WIDTH-1:0]        forwarder_rd_data,
    output logic                         forwarder_done,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready
`ifdef FORWARDER_STATS_EN
    ,
    output logic [31:0]                  stat_packets_sent,
    output logic [31:0]                  stat_stall_cycles
`endif
);

    localparam logic [PACKET_ADDR_WIDTH-1:0] ADDR_ONE = 1;

    fwd_state_t                   state;
    logic [PACKET_ADDR_WIDTH-1:0] len_q;
    logic                         inflight;
    logic                         inflight_last;
    logic [1:0]                   fifo_count;
    logic [1:0]                   occ_after;
    logic [DATA_WIDTH:0]          head_dat;
    logic                         pop;
    logic                         last_addr_hit;

    assign pop           = m_axis_tvalid & m_axis_tready;
    assign last_addr_hit = (forwarder_rd_addr == (len_q - ADDR_ONE));

    // Occupancy after this cycle's pop, counting the word still on its way back from memory.
    assign occ_after       = fifo_count + {1'b0, inflight} - {1'b0, pop};
    assign forwarder_rd_en = (state == FWD_STREAM) && (occ_after < FWD_FIFO_DEPTH);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state             <= FWD_IDLE;
            len_q             <= '0;
            forwarder_rd_addr <= '0;
            forwarder_done    <= 1'b0;
            inflight          <= 1'b0;
            inflight_last     <= 1'b0;
        end else begin
            inflight       <= forwarder_rd_en;
            inflight_last  <= forwarder_rd_en & last_addr_hit;
            forwarder_done <= 1'b0;
            case (state)
                FWD_IDLE: begin
                    if (ready_for_forwarder) begin
                        len_q             <= len_to_forwarder;
                        forwarder_rd_addr <= '0;
                        if (len_to_forwarder == '0) begin
                            state          <= FWD_DONE;
                            forwarder_done <= 1'b1;
                        end else begin
                            state <= FWD_STREAM;
                        end
                    end
                end
                FWD_STREAM: begin
                    if (forwarder_rd_en) begin
                        // Address parks on len-1 so it never runs past the packet.
                        if (last_addr_hit) begin
                            state <= FWD_DRAIN;
                        end else begin
                            forwarder_rd_addr <= forwarder_rd_addr + ADDR_ONE;
                        end
                    end
                end
                FWD_DRAIN: begin
                    if (pop && m_axis_tlast) begin
                        state          <= FWD_DONE;
                        forwarder_done <= 1'b1;
                    end
                end
                FWD_DONE: begin
                    state <= FWD_HOLD;
                end
                FWD_HOLD: begin
                    state <= FWD_IDLE;
                end
                default: begin
                    state <= FWD_IDLE;
                end
            endcase
        end
    end

    fwd_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (axi_aclk),
        .rst_n    (axi_aresetn),
        .push     (inflight),
        .push_dat ({inflight_last, forwarder_rd_data}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign m_axis_tdata  = head_dat[DATA_WIDTH-1:0];
    assign m_axis_tlast  = head_dat[DATA_WIDTH] & m_axis_tvalid;
    assign m_axis_tkeep  = '1;

`ifdef FORWARDER_STATS_EN
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            stat_packets_sent <= 32'd0;
            stat_stall_cycles <= 32'd0;
        end else begin
            if (forwarder_done) begin
                stat_packets_sent <= fwd_sat_inc(stat_packets_sent);
            end
            if (m_axis_tvalid && !m_axis_tready) begin
                stat_stall_cycles <= fwd_sat_inc(stat_stall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_forwarder.sv
// Bench for axis_forwarder: table of packet runs plus hand-written len=0, reset and stats sequences.
module tb_axis_forwarder;

    localparam int PAW = 10;
    localparam int DW  = 64;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    typedef struct {
        int len;
        int mode;
        bit b2b;
        int exp_reads;
        int exp_beats;
        int exp_dones;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ready = 1'b0;
    logic [PAW-1:0]  len_in = '0;
    logic [PAW-1:0]  rd_addr;
    logic            rd_en;
    logic [DW-1:0]   rd_data = '0;
    logic            done;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic            tvalid;
    logic            tready = 1'b1;
`ifdef FORWARDER_STATS_EN
    logic [31:0]     stat_pkts;
    logic [31:0]     stat_stalls;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int reads, beats, done_cnt, exp_addr, stall_obs;
    int first_rd, last_rd, first_bt, last_bt;
    bit mon_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    logic          prev_last;
    logic [15:0]   pkt_tag = 16'h0;
    beat_t         sb[$];
    vec_t          vecs[6];

    axis_forwarder dut (
        .axi_aclk            (clk),
        .axi_aresetn         (rst_n),
        .ready_for_forwarder (ready),
        .len_to_forwarder    (len_in),
        .forwarder_rd_addr   (rd_addr),
        .forwarder_rd_en     (rd_en),
        .forwarder_rd_data   (rd_data),
        .forwarder_done      (done),
        .m_axis_tdata        (tdata),
        .m_axis_tkeep        (tkeep),
        .m_axis_tlast        (tlast),
        .m_axis_tvalid       (tvalid),
        .m_axis_tready       (tready)
`ifdef FORWARDER_STATS_EN
        ,
        .stat_packets_sent   (stat_pkts),
        .stat_stall_cycles   (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input logic [PAW-1:0] a);
        return {16'hC0DE, pkt_tag, 22'h0, a};
    endfunction

    function automatic logic tready_for(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return ((n % 4) == 0) || ((n % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Packet memory: word appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= word(rd_addr);
    end

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (mon_en) begin
            if (rd_en) begin
                check("rd_addr", 64'(rd_addr), 64'(exp_addr));
                if (reads == 0) first_rd = cyc;
                last_rd = cyc;
                reads++;
                exp_addr++;
            end
            if (tvalid) check("tkeep", 64'(tkeep), 64'hFF);
            if (prev_stall) begin
                check("stall_tvalid", 64'(tvalid), 64'h1);
                check("stall_tdata", tdata, prev_dat);
                check("stall_tlast", 64'(tlast), 64'(prev_last));
            end
            if (tvalid && tready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL extra_beat: got beat %h, expected none (cycle %0d)", tdata, cyc);
                end else begin
                    e = sb.pop_front();
                    check("tdata", tdata, e.dat);
                    check("tlast", 64'(tlast), 64'(e.last));
                end
                if (beats == 0) first_bt = cyc;
                last_bt = cyc;
                beats++;
            end
            if (done) done_cnt++;
            if (tvalid && !tready) stall_obs++;
            prev_stall = tvalid && !tready;
            prev_dat   = tdata;
            prev_last  = tlast;
        end
    end

    task automatic start_packet(input int len);
        beat_t b;
        pkt_tag = pkt_tag + 16'h1;
        sb.delete();
        for (int i = 0; i < len; i++) begin
            b.dat  = word(PAW'(i));
            b.last = (i == len - 1);
            sb.push_back(b);
        end
        reads = 0; beats = 0; done_cnt = 0; exp_addr = 0; prev_stall = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic run_packet(input int len, input int mode);
        int n;
        @(posedge clk); #1;
        start_packet(len);
        ready  = 1'b1;
        len_in = PAW'(len);
        tready = tready_for(mode, 0);
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            len_in = 10'h2AA;
            tready = tready_for(mode, n);
        end
        ready  = 1'b0;
        tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int exp_done_pat[8];
        vecs[0] = '{len: 4, mode: 0, b2b: 1'b1, exp_reads: 4, exp_beats: 4, exp_dones: 1};
        vecs[1] = '{len: 4, mode: 1, b2b: 1'b0, exp_reads: 4, exp_beats: 4, exp_dones: 1};
        vecs[2] = '{len: 1, mode: 0, b2b: 1'b0, exp_reads: 1, exp_beats: 1, exp_dones: 1};
        vecs[3] = '{len: 0, mode: 0, b2b: 1'b0, exp_reads: 0, exp_beats: 0, exp_dones: 1};
        vecs[4] = '{len: 7, mode: 2, b2b: 1'b0, exp_reads: 7, exp_beats: 7, exp_dones: 1};
        vecs[5] = '{len: 9, mode: 0, b2b: 1'b1, exp_reads: 9, exp_beats: 9, exp_dones: 1};
        exp_done_pat = '{0, 1, 0, 0, 1, 0, 0, 1};

        #12;
        check("rst_tvalid", 64'(tvalid), 64'h0);
        check("rst_rd_en", 64'(rd_en), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_rd_addr", 64'(rd_addr), 64'h0);
        check("rst_tdata", tdata, 64'h0);
        #10 rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_packet(vecs[i].len, vecs[i].mode);
            check($sformatf("v%0d_reads", i), 64'(reads), 64'(vecs[i].exp_reads));
            check($sformatf("v%0d_beats", i), 64'(beats), 64'(vecs[i].exp_beats));
            check($sformatf("v%0d_dones", i), 64'(done_cnt), 64'(vecs[i].exp_dones));
            check($sformatf("v%0d_sb_left", i), 64'(sb.size()), 64'h0);
            if (vecs[i].b2b) begin
                check($sformatf("v%0d_rd_b2b", i), 64'(last_rd - first_rd), 64'(vecs[i].len - 1));
                check($sformatf("v%0d_beat_b2b", i), 64'(last_bt - first_bt), 64'(vecs[i].len - 1));
            end
        end

        // len=0 with ready held: done every third cycle, HOLD blocks immediate restart.
        @(posedge clk); #1;
        start_packet(0);
        ready = 1'b1; len_in = '0;
        foreach (exp_done_pat[k]) begin
            @(negedge clk); #1;
            check($sformatf("len0_done_%0d", k), 64'(done), 64'(exp_done_pat[k]));
            check("len0_tvalid", 64'(tvalid), 64'h0);
            check("len0_rd_en", 64'(rd_en), 64'h0);
        end
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of a len=8 packet, then a clean len=3 packet.
        start_packet(8);
        ready = 1'b1; len_in = 10'd8; tready = 1'b1;
        n = 0;
        while (beats < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_pkt_two_beats", 64'(beats >= 2), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tvalid", 64'(tvalid), 64'h0);
        check("arst_tlast", 64'(tlast), 64'h0);
        check("arst_rd_en", 64'(rd_en), 64'h0);
        check("arst_rd_addr", 64'(rd_addr), 64'h0);
        check("arst_done", 64'(done), 64'h0);
        check("arst_tdata", tdata, 64'h0);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_no_done", 64'(done_cnt), 64'h0);
        run_packet(3, 0);
        check("post_rst_reads", 64'(reads), 64'd3);
        check("post_rst_beats", 64'(beats), 64'd3);
        check("post_rst_dones", 64'(done_cnt), 64'd1);
        check("post_rst_sb_left", 64'(sb.size()), 64'h0);

`ifdef FORWARDER_STATS_EN
        @(negedge clk); #2 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        check("stat_pkts_rst", stat_pkts, 64'h0);
        stall_obs = 0;
        n = 0;
        for (int p = 0; p < 3; p++) begin
            run_packet(3, 1);
            n += stall_obs;
            stall_obs = 0;
        end
        check("stat_packets_sent", 64'(stat_pkts), 64'd3);
        check("stat_stall_cycles", 64'(stat_stalls), 64'(n));
`endif

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
